// File: rtl/apb_slave_32bit.sv
// ---------------------------------------------------------------------------
// apb_slave_32bit
//
// APB4 completer backed by a word-organised register memory of NumWords
// 32-bit entries. Every transfer completes with zero wait states. Writes are
// byte-strobed. Addresses at or beyond NumWords*4 are answered with p_slverr.
//
// Ports
//   p_clk      in   1  clock, rising edge
//   p_resetn   in   1  asynchronous active-low reset
//   p_addr     in  32  byte address (bits [1:0] ignored)
//   p_sel      in   1  slave select
//   p_enable   in   1  access-phase indicator
//   p_write    in   1  1 = write, 0 = read
//   p_wdata    in  32  write data
//   p_strb     in   4  byte-lane write strobes
//   p_rdata    out 32  registered read data
//   p_ready    out  1  transfer completion
//   p_slverr   out  1  transfer error, meaningful only with p_ready
//
// Handshake: a transfer is a setup cycle (p_sel=1, p_enable=0) followed by an
// access cycle (p_sel=1, p_enable=1). The access cycle is the "valid" side;
// p_ready is its "ready" and is raised in that same cycle, so the transfer
// completes at the rising edge that ends the access cycle. Outside an access
// cycle p_ready and p_slverr are 0.
// ---------------------------------------------------------------------------
module apb_slave_32bit #(
    parameter int NumWords = 64
) (
    input  logic        p_clk,
    input  logic        p_resetn,
    input  logic [31:0] p_addr,
    input  logic        p_sel,
    input  logic        p_enable,
    input  logic        p_write,
    input  logic [31:0] p_wdata,
    input  logic [3:0]  p_strb,
    output logic [31:0] p_rdata,
    output logic        p_ready,
    output logic        p_slverr
);

    localparam int          IdxW      = $clog2(NumWords);
    localparam logic [32:0] SizeBytes = 33'(NumWords) * 33'd4;

    logic [31:0]     mem_q [NumWords];
    logic [31:0]     rdata_q;
    logic [31:0]     rdata_d;
    logic [IdxW-1:0] word_idx;
    logic            in_range;
    logic            setup_ph;
    logic            access_ph;
    logic            wr_commit;

    // Byte offset within a word carries no meaning; accesses are word aligned.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^p_addr[1:0];

    assign word_idx  = p_addr[IdxW+1:2];
    assign in_range  = ({1'b0, p_addr} < SizeBytes);
    assign setup_ph  = p_sel & ~p_enable;
    assign access_ph = p_sel & p_enable;
    assign wr_commit = access_ph & p_write & in_range;

    // Gated by p_resetn so the response drops the instant reset is asserted,
    // even if the master still holds an access phase on the bus.
    assign p_ready  = p_resetn & access_ph;
    assign p_slverr = p_resetn & access_ph & ~in_range;
    assign p_rdata  = rdata_q;

    // Read data is captured in the setup cycle so it is stable for the whole
    // access cycle. Out-of-range reads return zero; idle cycles hold.
    always_comb begin
        rdata_d = rdata_q;
        if (setup_ph && !p_write) begin
            rdata_d = in_range ? mem_q[word_idx] : 32'h0;
        end
    end

    always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) begin
            rdata_q <= 32'h0;
            mem_q   <= '{default: 32'h0};
        end else begin
            rdata_q <= rdata_d;
            if (wr_commit) begin
                for (int b = 0; b < 4; b++) begin
                    if (p_strb[b]) begin
                        mem_q[word_idx][8*b +: 8] <= p_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_32bit.sv
// ---------------------------------------------------------------------------
// tb_apb_slave_32bit
//
// Directed bench for apb_slave_32bit (NumWords = 64). A small memory model
// predicts each transfer's response; the prediction is pushed onto exp_q when
// the transfer is driven and popped when the access phase is sampled.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_apb_slave_32bit;

    localparam int NumWords = 64;

    logic        p_clk;
    logic        p_resetn;
    logic [31:0] p_addr;
    logic        p_sel;
    logic        p_enable;
    logic        p_write;
    logic [31:0] p_wdata;
    logic [3:0]  p_strb;
    logic [31:0] p_rdata;
    logic        p_ready;
    logic        p_slverr;

    apb_slave_32bit #(.NumWords(NumWords)) dut (
        .p_clk    (p_clk),
        .p_resetn (p_resetn),
        .p_addr   (p_addr),
        .p_sel    (p_sel),
        .p_enable (p_enable),
        .p_write  (p_write),
        .p_wdata  (p_wdata),
        .p_strb   (p_strb),
        .p_rdata  (p_rdata),
        .p_ready  (p_ready),
        .p_slverr (p_slverr)
    );

    // ---------------- clock ----------------
    initial p_clk = 1'b0;
    always #5 p_clk = ~p_clk;

    // ---------------- scoreboard ----------------
    // entry = {is_read, expected slverr, expected rdata}
    logic [33:0] exp_q[$];
    logic [31:0] model_mem [NumWords];
    logic [31:0] last_rd;
    int          checks;
    int          errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NumWords; i++) model_mem[i] = 32'h0;
        last_rd = 32'h0;
    endtask

    // ---------------- driver ----------------
    // One two-cycle transfer. Leaves p_sel high at the end so a following
    // call produces a back-to-back transfer.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, input string tag);
        logic        in_rng;
        int          idx;
        logic [33:0] e;
        in_rng = (addr < 32'(NumWords * 4));
        idx    = int'(addr[7:2]);
        if (wr) begin
            exp_q.push_back({1'b0, ~in_rng, 32'h0});
            if (in_rng) begin
                for (int b = 0; b < 4; b++)
                    if (strb[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
            end
        end else begin
            e = {1'b1, ~in_rng, (in_rng ? model_mem[idx] : 32'h0)};
            exp_q.push_back(e);
            last_rd = e[31:0];
        end
        p_sel    = 1'b1;
        p_enable = 1'b0;
        p_write  = wr;
        p_addr   = addr;
        p_wdata  = wdata;
        p_strb   = strb;
        @(negedge p_clk);
        chk({tag, "_setup_ready"}, 32'(p_ready), 32'h0);
        @(posedge p_clk);
        #1 p_enable = 1'b1;
        @(negedge p_clk);
        e = exp_q.pop_front();
        chk({tag, "_ready"}, 32'(p_ready), 32'h1);
        chk({tag, "_slverr"}, 32'(p_slverr), 32'(e[32]));
        if (e[33]) chk({tag, "_rdata"}, p_rdata, e[31:0]);
        @(posedge p_clk);
        #1;
    endtask

    // One idle cycle with the bus fields scrambled.
    task automatic idle(input string tag);
        p_sel    = 1'b0;
        p_enable = 1'b0;
        p_addr   = $urandom;
        p_wdata  = $urandom;
        p_write  = 1'($urandom_range(0, 1));
        p_strb   = 4'($urandom_range(0, 15));
        @(negedge p_clk);
        chk({tag, "_ready"}, 32'(p_ready), 32'h0);
        chk({tag, "_slverr"}, 32'(p_slverr), 32'h0);
        chk({tag, "_hold"}, p_rdata, last_rd);
        @(posedge p_clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] rnd_vals [10];

    initial begin
        checks   = 0;
        errors   = 0;
        p_resetn = 1'b0;
        p_sel    = 1'b0;
        p_enable = 1'b0;
        p_write  = 1'b0;
        p_addr   = 32'h0;
        p_wdata  = 32'h0;
        p_strb   = 4'h0;
        model_clear();

        // Reset state
        repeat (2) @(posedge p_clk);
        @(negedge p_clk);
        chk("rst_rdata", p_rdata, 32'h0);
        chk("rst_ready", 32'(p_ready), 32'h0);
        chk("rst_slverr", 32'(p_slverr), 32'h0);
        @(posedge p_clk);
        #1 p_resetn = 1'b1;
        idle("idle0");
        xfer(1'b0, 32'h00, 32'h0, 4'h0, "rd00");
        xfer(1'b0, 32'h04, 32'h0, 4'hF, "rd04");
        xfer(1'b0, 32'hFC, 32'h0, 4'h0, "rdFC");
        idle("idle1");

        // Full-strobe write then read
        xfer(1'b1, 32'h08, 32'h12153524, 4'hF, "wr08");
        xfer(1'b0, 32'h08, 32'h0, 4'h0, "rd08");
        idle("idle2");

        // Byte strobes, including an all-zero strobe and an unaligned address
        xfer(1'b1, 32'h10, 32'hFFFFFFFF, 4'hF, "wr10a");
        xfer(1'b1, 32'h10, 32'h000000FF, 4'b0001, "wr10b");
        xfer(1'b1, 32'h10, 32'hAABBCCDD, 4'b1010, "wr10c");
        xfer(1'b0, 32'h10, 32'h0, 4'h0, "rd10");
        chk("strb_result", last_rd, 32'hAAFFCCFF);
        xfer(1'b1, 32'h10, 32'h11111111, 4'b0000, "wr10z");
        xfer(1'b0, 32'h13, 32'h0, 4'h0, "rd10u");
        idle("idle3");

        // Back-to-back random writes then reads
        for (int i = 0; i < 10; i++) begin
            rnd_vals[i] = $urandom;
            xfer(1'b1, 32'(i * 4), rnd_vals[i], 4'hF, "wr_rnd");
        end
        for (int i = 0; i < 10; i++) begin
            xfer(1'b0, 32'(i * 4), 32'h0, 4'h0, "rd_rnd");
            chk("rnd_match", last_rd, rnd_vals[i]);
        end
        idle("idle4");

        // Out of range: index bits alias word 0, which must not change
        xfer(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, "wr_oor");
        xfer(1'b0, 32'h100, 32'h0, 4'h0, "rd_oor");
        xfer(1'b0, 32'h00, 32'h0, 4'h0, "rd00_after_oor");
        xfer(1'b0, 32'hFFFFFFFC, 32'h0, 4'h0, "rd_oor_top");
        idle("idle5");

        // Async reset during the access phase of a write
        xfer(1'b0, 32'h08, 32'h0, 4'h0, "rd08_pre");
        p_sel    = 1'b1;
        p_enable = 1'b0;
        p_write  = 1'b1;
        p_addr   = 32'h04;
        p_wdata  = 32'h55;
        p_strb   = 4'hF;
        @(posedge p_clk);
        #1 p_enable = 1'b1;
        #2 p_resetn = 1'b0;
        #1;
        chk("arst_rdata", p_rdata, 32'h0);
        chk("arst_ready", 32'(p_ready), 32'h0);
        chk("arst_slverr", 32'(p_slverr), 32'h0);
        model_clear();
        @(posedge p_clk);
        #1;
        p_sel    = 1'b0;
        p_enable = 1'b0;
        @(posedge p_clk);
        #1 p_resetn = 1'b1;
        idle("idle6");
        xfer(1'b0, 32'h04, 32'h0, 4'h0, "rd04_after_arst");
        xfer(1'b0, 32'h08, 32'h0, 4'h0, "rd08_after_arst");
        idle("idle7");

        chk("exp_q_empty", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
